dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port A (CPU load/store path) and port B (debug/DMA loader).
- Registered ownership FSM with round-robin tie-break and a bounded burst length, so neither requester starves.
- Drives the memory's address, write-data, read and write strobes.
- Registers returned read data and flags it with a one-cycle valid pulse to the owning requester.

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between port A (CPU
// load/store) and port B (debug/DMA loader).
//
// Ports:
//   clkIn, resetIn               clock (rising edge), async active-low reset
//   A_*/B_* ReqIn, WriteIn,      requester command, held until its GntOut
//           AddrIn, DataIn
//   A_*/B_* GntOut               access performed this cycle (combinational)
//   A_*/B_* DataOut, ValidOut    registered read data, one-cycle valid pulse
//   Mem_AddrOut, Mem_DataOut,    memory address, write data and strobes,
//   Mem_ReadOut, Mem_WriteOut    all zero when no access is granted
//   Mem_DataIn                   combinational read data from the memory
//   BusyOut                      an owner is currently selected
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clkIn,
    input  logic              resetIn,
    input  logic              A_ReqIn,
    input  logic              A_WriteIn,
    input  logic [ADDR_W-1:0] A_AddrIn,
    input  logic [DATA_W-1:0] A_DataIn,
    output logic              A_GntOut,
    output logic [DATA_W-1:0] A_DataOut,
    output logic              A_ValidOut,
    input  logic              B_ReqIn,
    input  logic              B_WriteIn,
    input  logic [ADDR_W-1:0] B_AddrIn,
    input  logic [DATA_W-1:0] B_DataIn,
    output logic              B_GntOut,
    output logic [DATA_W-1:0] B_DataOut,
    output logic              B_ValidOut,
    output logic [ADDR_W-1:0] Mem_AddrOut,
    output logic [DATA_W-1:0] Mem_DataOut,
    output logic              Mem_ReadOut,
    output logic              Mem_WriteOut,
    input  logic [DATA_W-1:0] Mem_DataIn,
    output logic              BusyOut
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [CNT_W-1:0] cntInc;
    logic             lastServed;
    logic             lastServedNext;
    logic             grantA;
    logic             grantB;

    // lastServed: 1 = B was served last, 0 = A.
    // Gating with resetIn keeps the write strobe low from the instant
    // reset is asserted, independent of the state register's reset path.
    assign grantA = resetIn && (state == OWN_A) && A_ReqIn;
    assign grantB = resetIn && (state == OWN_B) && B_ReqIn;

    assign A_GntOut = grantA;
    assign B_GntOut = grantB;
    assign BusyOut  = (state != IDLE);

    always_comb begin
        Mem_AddrOut  = '0;
        Mem_DataOut  = '0;
        Mem_ReadOut  = 1'b0;
        Mem_WriteOut = 1'b0;
        if (grantA) begin
            Mem_AddrOut  = A_AddrIn;
            Mem_DataOut  = A_DataIn;
            Mem_ReadOut  = !A_WriteIn;
            Mem_WriteOut = A_WriteIn;
        end else if (grantB) begin
            Mem_AddrOut  = B_AddrIn;
            Mem_DataOut  = B_DataIn;
            Mem_ReadOut  = !B_WriteIn;
            Mem_WriteOut = B_WriteIn;
        end
    end

    assign cntInc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    // The burst limit is judged on the post-grant count, so the owner
    // gets exactly MAX_BURST grants before a waiting peer takes over.
    always_comb begin
        stateNext      = state;
        cntNext        = cnt;
        lastServedNext = lastServed;
        case (state)
            IDLE: begin
                cntNext = '0;
                if (A_ReqIn && B_ReqIn) begin
                    stateNext = lastServed ? OWN_A : OWN_B;
                end else if (A_ReqIn) begin
                    stateNext = OWN_A;
                end else if (B_ReqIn) begin
                    stateNext = OWN_B;
                end
            end
            OWN_A: begin
                if (grantA) begin
                    cntNext        = cntInc;
                    lastServedNext = 1'b0;
                end
                if (B_ReqIn && (!A_ReqIn || cntInc >= CNT_MAX)) begin
                    stateNext = OWN_B;
                    cntNext   = '0;
                end else if (!A_ReqIn) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            end
            OWN_B: begin
                if (grantB) begin
                    cntNext        = cntInc;
                    lastServedNext = 1'b1;
                end
                if (A_ReqIn && (!B_ReqIn || cntInc >= CNT_MAX)) begin
                    stateNext = OWN_A;
                    cntNext   = '0;
                end else if (!B_ReqIn) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state      <= IDLE;
            cnt        <= '0;
            lastServed <= 1'b1;
            A_DataOut  <= '0;
            B_DataOut  <= '0;
            A_ValidOut <= 1'b0;
            B_ValidOut <= 1'b0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            lastServed <= lastServedNext;
            A_ValidOut <= grantA && !A_WriteIn;
            B_ValidOut <= grantB && !B_WriteIn;
            if (grantA && !A_WriteIn) begin
                A_DataOut <= Mem_DataIn;
            end
            if (grantB && !B_WriteIn) begin
                B_DataOut <= Mem_DataIn;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed bench for dmem_arbiter with a
// transaction-level ownership/memory reference model.
module tb_dmem_arbiter;

    localparam int MB = 4;

    logic        clkIn = 1'b0;
    logic        resetIn = 1'b0;
    logic        A_ReqIn = 1'b0, A_WriteIn = 1'b0;
    logic [31:0] A_AddrIn = '0, A_DataIn = '0;
    logic        B_ReqIn = 1'b0, B_WriteIn = 1'b0;
    logic [31:0] B_AddrIn = '0, B_DataIn = '0;
    logic        A_GntOut, A_ValidOut, B_GntOut, B_ValidOut;
    logic [31:0] A_DataOut, B_DataOut;
    logic [31:0] Mem_AddrOut, Mem_DataOut, Mem_DataIn;
    logic        Mem_ReadOut, Mem_WriteOut, BusyOut;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
        .clkIn(clkIn), .resetIn(resetIn),
        .A_ReqIn(A_ReqIn), .A_WriteIn(A_WriteIn), .A_AddrIn(A_AddrIn),
        .A_DataIn(A_DataIn), .A_GntOut(A_GntOut), .A_DataOut(A_DataOut),
        .A_ValidOut(A_ValidOut),
        .B_ReqIn(B_ReqIn), .B_WriteIn(B_WriteIn), .B_AddrIn(B_AddrIn),
        .B_DataIn(B_DataIn), .B_GntOut(B_GntOut), .B_DataOut(B_DataOut),
        .B_ValidOut(B_ValidOut),
        .Mem_AddrOut(Mem_AddrOut), .Mem_DataOut(Mem_DataOut),
        .Mem_ReadOut(Mem_ReadOut), .Mem_WriteOut(Mem_WriteOut),
        .Mem_DataIn(Mem_DataIn), .BusyOut(BusyOut)
    );

    always #5 clkIn = ~clkIn;

    // memory stand-in, loaded from the reference image on the first edge
    logic [31:0] mem [0:255];
    logic [31:0] refMem [0:255];
    logic        memReady = 1'b0;
    assign Mem_DataIn = mem[Mem_AddrOut[7:0]];
    always @(posedge clkIn) begin
        if (!memReady) begin
            for (int i = 0; i < 256; i++) mem[i] <= refMem[i];
            memReady <= 1'b1;
        end else if (Mem_WriteOut) begin
            mem[Mem_AddrOut[7:0]] <= Mem_DataOut;
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t qA[$], qB[$];
    int   gapA = 0, gapB = 0, maxGap = 0;

    // reference model: owner 0=none 1=A 2=B
    int          mOwner = 0, mCnt = 0;
    bit          mLastB = 1'b1;
    bit          mValidA = 1'b0, mValidB = 1'b0;
    logic [31:0] mDataA = '0, mDataB = '0;

    logic        oGntA = 1'b0, oGntB = 1'b0;
    int          cycNo = 0, overlap = 0;
    int          gntLog[$], gntCyc[$];
    logic [31:0] vLogA[$];

    int checks = 0;
    int failures = 0;

    task automatic drive();
        if (gapA > 0) begin
            gapA--;
            A_ReqIn = 1'b0;
        end else if (qA.size() > 0) begin
            A_ReqIn = 1'b1;
            A_WriteIn = qA[0].wr;
            A_AddrIn = qA[0].addr;
            A_DataIn = qA[0].data;
        end else begin
            A_ReqIn = 1'b0;
        end
        if (gapB > 0) begin
            gapB--;
            B_ReqIn = 1'b0;
        end else if (qB.size() > 0) begin
            B_ReqIn = 1'b1;
            B_WriteIn = qB[0].wr;
            B_AddrIn = qB[0].addr;
            B_DataIn = qB[0].data;
        end else begin
            B_ReqIn = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit ga, gb, xr, yr;
        if (!resetIn) begin
            mOwner = 0; mCnt = 0; mLastB = 1'b1;
            mValidA = 1'b0; mValidB = 1'b0;
            mDataA = '0; mDataB = '0;
            return;
        end
        ga = (mOwner == 1) && A_ReqIn;
        gb = (mOwner == 2) && B_ReqIn;
        mValidA = ga && !A_WriteIn;
        mValidB = gb && !B_WriteIn;
        if (mValidA) mDataA = refMem[A_AddrIn[7:0]];
        if (mValidB) mDataB = refMem[B_AddrIn[7:0]];
        if (ga && A_WriteIn) refMem[A_AddrIn[7:0]] = A_DataIn;
        if (gb && B_WriteIn) refMem[B_AddrIn[7:0]] = B_DataIn;
        if (mOwner == 0) begin
            if (A_ReqIn && B_ReqIn) mOwner = mLastB ? 1 : 2;
            else if (A_ReqIn) mOwner = 1;
            else if (B_ReqIn) mOwner = 2;
            mCnt = 0;
        end else begin
            xr = (mOwner == 1) ? A_ReqIn : B_ReqIn;
            yr = (mOwner == 1) ? B_ReqIn : A_ReqIn;
            if (xr) begin
                mCnt = (mCnt + 1 > MB) ? MB : mCnt + 1;
                mLastB = (mOwner == 2);
            end
            if (yr && (!xr || mCnt >= MB)) begin
                mOwner = 3 - mOwner;
                mCnt = 0;
            end else if (!xr) begin
                mOwner = 0;
                mCnt = 0;
            end
        end
    endtask

    task automatic sample();
        @(negedge clkIn);
        oGntA = A_GntOut;
        oGntB = B_GntOut;
        if (oGntA) begin gntLog.push_back(1); gntCyc.push_back(cycNo); end
        if (oGntB) begin gntLog.push_back(2); gntCyc.push_back(cycNo); end
        if (oGntA && oGntB) overlap++;
        if (A_ValidOut) vLogA.push_back(A_DataOut);
    endtask

    task automatic advance();
        @(posedge clkIn);
        model_edge();
        cycNo++;
        #1;
        if (oGntA && qA.size() > 0) begin
            qA.delete(0);
            gapA = $urandom_range(0, maxGap);
        end
        if (oGntB && qB.size() > 0) begin
            qB.delete(0);
            gapB = $urandom_range(0, maxGap);
        end
        drive();
    endtask

    task automatic drain(input int maxCyc, output bit timedOut);
        int n;
        n = 0;
        timedOut = 1'b0;
        while ((qA.size() > 0 || qB.size() > 0) && !timedOut) begin
            sample();
            advance();
            n++;
            if (n >= maxCyc) timedOut = 1'b1;
        end
        repeat (3) begin
            sample();
            advance();
        end
    endtask

    task automatic clear_logs();
        gntLog.delete();
        gntCyc.delete();
        vLogA.delete();
        overlap = 0;
    endtask

    task automatic do_reset();
        resetIn = 1'b0;
        qA.delete(); qB.delete();
        gapA = 0; gapB = 0;
        A_ReqIn = 1'b0; B_ReqIn = 1'b0;
        @(posedge clkIn);
        model_edge();
        #1;
        resetIn = 1'b1;
        oGntA = 1'b0; oGntB = 1'b0;
    endtask

    task automatic test_reset();
        A_ReqIn = 1'b1; B_ReqIn = 1'b1;
        A_WriteIn = 1'b1; A_AddrIn = 32'h44;
        @(posedge clkIn);
        model_edge();
        #1;
        checks++;
        if ({BusyOut, A_GntOut, B_GntOut, Mem_WriteOut, Mem_ReadOut,
             A_ValidOut, B_ValidOut} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {BusyOut, A_GntOut,
                     B_GntOut, Mem_WriteOut, Mem_ReadOut, A_ValidOut,
                     B_ValidOut});
        end
        checks++;
        if ({Mem_AddrOut, Mem_DataOut, A_DataOut, B_DataOut} !== 128'b0) begin
            failures++;
            $display("FAIL reset_data got=%h %h %h %h exp=0", Mem_AddrOut,
                     Mem_DataOut, A_DataOut, B_DataOut);
        end
        A_ReqIn = 1'b0; B_ReqIn = 1'b0; A_WriteIn = 1'b0;
        @(posedge clkIn);
        model_edge();
        #1;
        resetIn = 1'b1;
    endtask

    task automatic test_write_read();
        qA.push_back(txn_t'{1'b1, 32'd5, 32'hDEADBEEF});
        qA.push_back(txn_t'{1'b0, 32'd5, 32'h0});
        drive();
        sample();
        checks++;
        if ({A_GntOut, BusyOut, Mem_WriteOut} !== 3'b000) begin
            failures++;
            $display("FAIL wr_idle_cycle got=%b exp=000",
                     {A_GntOut, BusyOut, Mem_WriteOut});
        end
        advance();
        sample();
        checks++;
        if ({A_GntOut, Mem_WriteOut, Mem_ReadOut} !== 3'b110) begin
            failures++;
            $display("FAIL wr_grant got=%b exp=110",
                     {A_GntOut, Mem_WriteOut, Mem_ReadOut});
        end
        checks++;
        if ({Mem_AddrOut, Mem_DataOut} !== {32'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL wr_bus got=%h/%h exp=5/deadbeef",
                     Mem_AddrOut, Mem_DataOut);
        end
        advance();
        sample();
        checks++;
        if ({A_GntOut, Mem_WriteOut, Mem_ReadOut, Mem_AddrOut} !==
            {3'b101, 32'd5}) begin
            failures++;
            $display("FAIL rd_grant got=%b addr=%h exp=101 addr=5",
                     {A_GntOut, Mem_WriteOut, Mem_ReadOut}, Mem_AddrOut);
        end
        advance();
        sample();
        checks++;
        if ({A_ValidOut, A_DataOut, Mem_WriteOut} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            failures++;
            $display("FAIL rd_valid got=%b/%h exp=1/deadbeef",
                     A_ValidOut, A_DataOut);
        end
        advance();
        sample();
        checks++;
        if ({A_ValidOut, A_DataOut} !== {1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL rd_hold got=%b/%h exp=0/deadbeef",
                     A_ValidOut, A_DataOut);
        end
        advance();
    endtask

    task automatic test_tie();
        bit to;
        do_reset();
        clear_logs();
        qA.push_back(txn_t'{1'b0, 32'd1, 32'h0});
        qB.push_back(txn_t'{1'b0, 32'd2, 32'h0});
        drive();
        drain(50, to);
        checks++;
        if ({to, 8'(gntLog.size()), 8'(gntLog[0]), 8'(gntLog[1])} !==
            {1'b0, 8'd2, 8'd1, 8'd2}) begin
            failures++;
            $display("FAIL tie_first to=%0d n=%0d first=%0d second=%0d exp=0 2 1 2",
                     to, gntLog.size(), gntLog[0], gntLog[1]);
        end
        checks++;
        if (gntCyc[1] - gntCyc[0] !== 2) begin
            failures++;
            $display("FAIL tie_bubble got=%0d exp=2", gntCyc[1] - gntCyc[0]);
        end
        qA.push_back(txn_t'{1'b0, 32'd3, 32'h0});
        drive();
        drain(50, to);
        clear_logs();
        qA.push_back(txn_t'{1'b0, 32'd1, 32'h0});
        qB.push_back(txn_t'{1'b0, 32'd2, 32'h0});
        drive();
        drain(50, to);
        checks++;
        if ({to, 8'(gntLog[0]), 8'(gntLog[1])} !== {1'b0, 8'd2, 8'd1}) begin
            failures++;
            $display("FAIL tie_second to=%0d first=%0d second=%0d exp=0 2 1",
                     to, gntLog[0], gntLog[1]);
        end
    endtask

    task automatic test_burst();
        bit to;
        int exp[$];
        do_reset();
        clear_logs();
        for (int i = 0; i < 10; i++) qA.push_back(txn_t'{1'b0, 32'(16 + i), 32'h0});
        for (int i = 0; i < 6; i++) qB.push_back(txn_t'{1'b0, 32'(32 + i), 32'h0});
        repeat (4) exp.push_back(1);
        repeat (4) exp.push_back(2);
        repeat (4) exp.push_back(1);
        repeat (2) exp.push_back(2);
        repeat (2) exp.push_back(1);
        drive();
        drain(100, to);
        checks++;
        if ({to, gntLog.size() == exp.size(), overlap == 0} !== 3'b011) begin
            failures++;
            $display("FAIL burst_shape to=%0d n=%0d exp_n=%0d overlap=%0d",
                     to, gntLog.size(), exp.size(), overlap);
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (gntLog[i] !== exp[i]) begin
                failures++;
                $display("FAIL burst_order[%0d] got=%0d exp=%0d",
                         i, gntLog[i], exp[i]);
            end
        end
    endtask

    task automatic test_stream();
        bit to;
        clear_logs();
        for (int i = 0; i < 8; i++) qA.push_back(txn_t'{1'b0, 32'(i), 32'h0});
        drive();
        drain(50, to);
        checks++;
        if ({to, 8'(gntLog.size()), 8'(vLogA.size()), 8'(gntCyc[7] - gntCyc[0])}
            !== {1'b0, 8'd8, 8'd8, 8'd7}) begin
            failures++;
            $display("FAIL stream_shape to=%0d gnts=%0d valids=%0d span=%0d exp=0 8 8 7",
                     to, gntLog.size(), vLogA.size(), gntCyc[7] - gntCyc[0]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (vLogA[i] !== refMem[i]) begin
                failures++;
                $display("FAIL stream_data[%0d] got=%h exp=%h",
                         i, vLogA[i], refMem[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [31:0] old;
        old = refMem[9];
        qB.push_back(txn_t'{1'b1, 32'd9, ~old});
        drive();
        sample();
        advance();
        #2;
        checks++;
        if ({B_GntOut, Mem_WriteOut} !== 2'b11) begin
            failures++;
            $display("FAIL rstmid_pre got=%b exp=11", {B_GntOut, Mem_WriteOut});
        end
        resetIn = 1'b0;
        #1;
        checks++;
        if ({Mem_WriteOut, B_GntOut, A_GntOut, BusyOut, A_ValidOut,
             B_ValidOut, Mem_AddrOut} !== 38'b0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b addr=%h exp=0",
                     {Mem_WriteOut, B_GntOut, A_GntOut, BusyOut, A_ValidOut,
                      B_ValidOut}, Mem_AddrOut);
        end
        qB.delete();
        B_ReqIn = 1'b0;
        @(posedge clkIn);
        model_edge();
        #1;
        checks++;
        if (mem[9] !== old) begin
            failures++;
            $display("FAIL rstmid_mem got=%h exp=%h", mem[9], old);
        end
        resetIn = 1'b1;
        oGntA = 1'b0; oGntB = 1'b0;
        clear_logs();
        qA.push_back(txn_t'{1'b0, 32'd1, 32'h0});
        qB.push_back(txn_t'{1'b0, 32'd2, 32'h0});
        drive();
        drain(50, to);
        checks++;
        if ({to, 8'(gntLog[0])} !== {1'b0, 8'd1}) begin
            failures++;
            $display("FAIL rstmid_restart to=%0d first=%0d exp=0 1", to, gntLog[0]);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            sample();
            checks++;
            if ({BusyOut, Mem_ReadOut, Mem_WriteOut, Mem_AddrOut} !== 35'b0) begin
                failures++;
                $display("FAIL idle[%0d] got=%b addr=%h exp=0", i,
                         {BusyOut, Mem_ReadOut, Mem_WriteOut}, Mem_AddrOut);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic        eGA, eGB, eRd, eWr;
        logic [31:0] eAddr, eData;
        do_reset();
        maxGap = 2;
        for (int c = 0; c < 400; c++) begin
            if (qA.size() < 3 && $urandom_range(0, 2) == 0)
                qA.push_back(txn_t'{1'($urandom), $urandom & 32'hFFFF_FF0F, $urandom});
            if (qB.size() < 3 && $urandom_range(0, 2) == 0)
                qB.push_back(txn_t'{1'($urandom), $urandom & 32'hFFFF_FF0F, $urandom});
            sample();
            eGA = (mOwner == 1) && A_ReqIn;
            eGB = (mOwner == 2) && B_ReqIn;
            eAddr = eGA ? A_AddrIn : (eGB ? B_AddrIn : 32'h0);
            eData = eGA ? A_DataIn : (eGB ? B_DataIn : 32'h0);
            eWr = eGA ? A_WriteIn : (eGB ? B_WriteIn : 1'b0);
            eRd = (eGA || eGB) && !eWr;
            checks++;
            if ({A_GntOut, B_GntOut, Mem_ReadOut, Mem_WriteOut, BusyOut} !==
                {eGA, eGB, eRd, eWr, mOwner != 0}) begin
                failures++;
                $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c,
                         {A_GntOut, B_GntOut, Mem_ReadOut, Mem_WriteOut, BusyOut},
                         {eGA, eGB, eRd, eWr, mOwner != 0});
            end
            checks++;
            if ({Mem_AddrOut, Mem_DataOut} !== {eAddr, eData}) begin
                failures++;
                $display("FAIL rnd_bus c=%0d got=%h/%h exp=%h/%h", c,
                         Mem_AddrOut, Mem_DataOut, eAddr, eData);
            end
            checks++;
            if ({A_ValidOut, B_ValidOut, A_DataOut, B_DataOut} !==
                {mValidA, mValidB, mDataA, mDataB}) begin
                failures++;
                $display("FAIL rnd_read c=%0d got=%b%b %h %h exp=%b%b %h %h", c,
                         A_ValidOut, B_ValidOut, A_DataOut, B_DataOut,
                         mValidA, mValidB, mDataA, mDataB);
            end
            advance();
        end
        maxGap = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = $urandom;
        test_reset();
        test_write_read();
        test_tie();
        test_burst();
        test_stream();
        test_reset_mid();
        test_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
